alu_op_sequencer: RTL and testbench

EX-stage controller that sequences the ALU for every ALUCtrl code.
- Single-cycle ops (and/or/add/sub) complete combinationally in the issue cycle.
- mul (3'b011) runs as a fixed-latency iterative shift-add. The block raises stall_o to hold the pipeline until the product is ready.
- Sits between ALU_Control's ALUCtrl output and the EX/MEM latch. stall_o feeds the hazard/stall logic for PC, IF/ID and ID/EX.

---
 rtl/alu_defs.sv | 25 ++
 rtl/mul_shift_add.sv | 80 ++++++++
 rtl/alu_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
`default_nettype none
// ============================================================================
// Package : alu_defs
// Purpose : Shared ALUCtrl op codes and sequencer state encoding used by the
//           EX-stage ALU sequencer and its iterative multiplier.
// Contents: ALU_AND/OR/ADD/MUL/SUB code constants, seq_state_e enum.
// Revision: 1.0 - initial release
// ============================================================================
package alu_defs;

    // ALUCtrl codes driven by ALU_Control
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // Sequencer states
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } seq_state_e;

endpackage : alu_defs
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
// Module  : mul_shift_add
// Purpose : Iterative shift-add multiplier datapath. One multiplier bit is
//           consumed per step; a full product takes exactly WIDTH steps.
// Ports   : clk_i      - clock, rising edge
//           rst_i      - asynchronous active-low reset
//           clr_i      - abort: clears the iteration counter
//           load_i     - latch operands, clear accumulator and counter
//           step_i     - perform one shift-add iteration
//           mcand_i    - multiplicand (latched on load)
//           mplier_i   - multiplier   (latched on load)
//           last_o     - current step is the final one (cnt == WIDTH-1)
//           product_o  - accumulator (low WIDTH bits of the product)
// Revision: 1.0 - initial release
// ============================================================================
module mul_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             last_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            // Sum wraps at WIDTH bits; only the low half of the product is kept
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last_o    = (cnt_q == CNT_LAST);
    assign product_o = acc_q;

endmodule : mul_shift_add
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_op_sequencer
// Purpose : EX-stage ALU controller. and/or/add/sub complete in the issue
//           cycle; mul runs on an iterative shift-add unit while stall_o
//           holds the pipeline for WIDTH+1 cycles.
// Ports   : clk_i     - clock, rising edge
//           rst_i     - asynchronous active-low reset
//           valid_i   - EX holds a valid instruction
//           flush_i   - kill the EX instruction / abort multiply
//           ALUCtrl_i - op code
//           data1_i   - operand A / multiplicand
//           data2_i   - operand B / multiplier
//           result_o  - ALU result, valid with done_o
//           zero_o    - result_o == 0
//           done_o    - result_o valid this cycle
//           stall_o   - hold PC, IF/ID, ID/EX and EX/MEM enable
// Revision: 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             done_o,
    output logic             stall_o
);

    seq_state_e       state_q, state_d;
    logic             done_q,  done_d;

    logic             mul_load;
    logic             mul_step;
    logic             mul_clr;
    logic             mul_last;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] result_d;
    logic             done_out_d;
    logic             stall_out_d;

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (mul_clr),
        .load_i    (mul_load),
        .step_i    (mul_step),
        .mcand_i   (data1_i),
        .mplier_i  (data2_i),
        .last_o    (mul_last),
        .product_o (mul_product)
    );

    // Single-cycle ops; undefined codes produce zero
    always_comb begin
        single_res = '0;
        case (ALUCtrl_i)
            ALU_AND: single_res = data1_i & data2_i;
            ALU_OR:  single_res = data1_i | data2_i;
            ALU_ADD: single_res = data1_i + data2_i;
            ALU_SUB: single_res = data1_i - data2_i;
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        mul_load    = 1'b0;
        mul_step    = 1'b0;
        mul_clr     = 1'b0;
        result_d    = '0;
        done_out_d  = 1'b0;
        stall_out_d = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            done_d  = 1'b0;
            mul_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (done_q) begin
                        // Finished product is handed over; the mul still in
                        // EX this cycle is the one being retired, not a new one
                        result_d   = mul_product;
                        done_out_d = 1'b1;
                        done_d     = 1'b0;
                    end else if (valid_i) begin
                        if (ALUCtrl_i == ALU_MUL) begin
                            stall_out_d = 1'b1;
                            mul_load    = 1'b1;
                            state_d     = MUL_RUN;
                        end else begin
                            result_d   = single_res;
                            done_out_d = 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    stall_out_d = 1'b1;
                    mul_step    = 1'b1;
                    if (mul_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Outputs are forced quiet while reset is asserted, even if EX holds a
    // valid instruction
    assign result_o = rst_i ? result_d : '0;
    assign done_o   = rst_i & done_out_d;
    assign stall_o  = rst_i & stall_out_d;
    assign zero_o   = (result_o == '0);

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_op_sequencer
// Purpose : Randomized scoreboard bench for alu_op_sequencer. The driver
//           pushes expected results (from a plain-arithmetic reference) and
//           expected latency; a negedge monitor pops on done_o and checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         flush_i;
    logic [2:0]   ALUCtrl_i;
    logic [W-1:0] data1_i;
    logic [W-1:0] data2_i;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         done_o;
    logic         stall_o;

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .done_o    (done_o),
        .stall_o   (stall_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    function automatic logic [W-1:0] ref_model(input logic [2:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b011: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return p[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    // Monitor
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i !== 1'b1) begin
            compared++;
            if (done_o !== 1'b0 || stall_o !== 1'b0 || result_o !== '0 || zero_o !== 1'b1) begin
                mismatched++;
                $display("FAIL reset_outputs: got done=%b stall=%b result=%h zero=%b, want 0 0 0 1",
                         done_o, stall_o, result_o, zero_o);
            end
        end else if (flush_i === 1'b1) begin
            compared++;
            if (done_o !== 1'b0 || stall_o !== 1'b0 || result_o !== '0 || zero_o !== 1'b1) begin
                mismatched++;
                $display("FAIL flush_outputs: got done=%b stall=%b result=%h zero=%b, want 0 0 0 1",
                         done_o, stall_o, result_o, zero_o);
            end
        end else if (done_o === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: got done=1 result=%h, want no completion", result_o);
            end else begin
                e = sb.pop_front();
                if (result_o !== e.res || zero_o !== (e.res == '0) ||
                    stall_o !== 1'b0 || (cyc - e.t0) != e.lat) begin
                    mismatched++;
                    $display("FAIL result: got res=%h zero=%b stall=%b lat=%0d, want res=%h zero=%b stall=0 lat=%0d",
                             result_o, zero_o, stall_o, cyc - e.t0, e.res, (e.res == '0), e.lat);
                end
            end
        end else if (valid_i === 1'b1) begin
            // A valid instruction that has not completed must hold the pipe
            compared++;
            if (stall_o !== 1'b1 || result_o !== '0) begin
                mismatched++;
                $display("FAIL stall_hold: got stall=%b result=%h, want stall=1 result=0",
                         stall_o, result_o);
            end
        end else begin
            compared++;
            if (stall_o !== 1'b0 || result_o !== '0 || zero_o !== 1'b1) begin
                mismatched++;
                $display("FAIL bubble: got stall=%b result=%h zero=%b, want 0 0 1",
                         stall_o, result_o, zero_o);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        e.res = ref_model(op, a, b);
        e.lat = (op == 3'b011) ? W + 1 : 0;
        e.t0  = cyc;
        sb.push_back(e);
        valid_i   = 1'b1;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (done_o !== 1'b1 && n < 100);
        if (done_o !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: op=%b got no done_o within %0d cycles, want done_o", op, n);
            sb.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic bubble();
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [2:0] ops [8];
        logic [2:0] op;
        logic [W-1:0] a, b;
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b011, 3'b100, 3'b101, 3'b111};

        rst_i     = 1'b0;
        valid_i   = 1'b1;
        flush_i   = 1'b0;
        ALUCtrl_i = 3'b010;
        data1_i   = 32'd5;
        data2_i   = 32'd7;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Directed single-cycle and multiply cases
        issue(3'b010, 32'd5, 32'd7);
        issue(3'b110, 32'd7, 32'd7);
        issue(3'b011, 32'd7, 32'd6);
        issue(3'b010, 32'd9, 32'd1);
        issue(3'b011, 32'hFFFF_FFFF, 32'd2);
        issue(3'b011, 32'h0001_0000, 32'h0001_0000);

        // Flush in the middle of a multiply
        valid_i   = 1'b1;
        ALUCtrl_i = 3'b011;
        data1_i   = 32'd9;
        data2_i   = 32'd9;
        repeat (10) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        issue(3'b010, 32'd1, 32'd1);

        // Reset in the middle of a multiply
        valid_i   = 1'b1;
        ALUCtrl_i = 3'b011;
        data1_i   = 32'd11;
        data2_i   = 32'd13;
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        issue(3'b010, 32'd3, 32'd4);

        // Back-to-back multiplies and an undefined code
        issue(3'b011, 32'd3, 32'd3);
        issue(3'b011, 32'd4, 32'd5);
        issue(3'b101, 32'h1234_5678, 32'h0F0F_0F0F);
        bubble();

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 7)];
            a  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? a  : W'($urandom);
            issue(op, a, b);
            if ($urandom_range(0, 3) == 0) bubble();
        end

        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_alu_op_sequencer
`default_nettype wire
